// File: rtl/xy_vector_gen.sv
// xy_vector_gen: traces a closed polygon from a writable vertex table onto X/Y DAC codes (option XY_TRANSFORM_EN adds xform).
// Latency: run sampled high at edge N gives the first sample after edge N+2; each segment is 2^step_shift+1 cycles.
// Backpressure: none downstream; ena low freezes the walker and outputs, table writes still land.
module xy_vector_gen #(
    parameter int DAC_W     = 8,
    parameter int NPTS      = 16,
    parameter int ADDR_W    = 4,
    parameter int MAX_SHIFT = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              run,
    input  logic [ADDR_W-1:0] last_idx,
    input  logic [2:0]        step_shift,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DAC_W-1:0]  wr_x,
    input  logic [DAC_W-1:0]  wr_y,
    input  logic              wr_blank,
`ifdef XY_TRANSFORM_EN
    input  logic [1:0]        xform,
`endif
    output logic [DAC_W-1:0]  xdac,
    output logic [DAC_W-1:0]  ydac,
    output logic              blank,
    output logic              frame_pulse,
    output logic              busy
);
    localparam int                PW        = DAC_W + MAX_SHIFT + 2;
    localparam logic [ADDR_W-1:0] LAST_MAX  = ADDR_W'(NPTS - 1);
    localparam logic [2:0]        SHIFT_MAX = 3'(MAX_SHIFT);

    typedef struct packed {
        logic [DAC_W-1:0] x;
        logic [DAC_W-1:0] y;
        logic             blank;
    } vtx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STEP  = 2'd2
    } state_t;

    vtx_t                  tbl [NPTS];
    state_t                state;
    vtx_t                  s_q;
    vtx_t                  v_s;
    vtx_t                  v_e;
    logic signed [DAC_W:0] dx_q;
    logic signed [DAC_W:0] dy_q;
    logic [MAX_SHIFT-1:0]  k_q;
    logic [MAX_SHIFT-1:0]  k_last;
    logic [ADDR_W-1:0]     idx;
    logic [ADDR_W-1:0]     last_q;
    logic [ADDR_W-1:0]     last_clamp;
    logic [ADDR_W-1:0]     nxt_idx;
    logic [2:0]            shift_q;
    logic [2:0]            shift_clamp;
    logic signed [PW-1:0]  prod_x;
    logic signed [PW-1:0]  prod_y;
    logic [DAC_W-1:0]      x_smp;
    logic [DAC_W-1:0]      y_smp;
    logic [DAC_W-1:0]      x_out;
    logic [DAC_W-1:0]      y_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NPTS; n++) begin
                tbl[n] <= '0;
            end
        end else if (wr_en && (32'(wr_addr) < 32'(NPTS))) begin
            tbl[wr_addr] <= {wr_x, wr_y, wr_blank};
        end
    end

    always_comb begin
        last_clamp  = (32'(last_idx) >= 32'(NPTS)) ? LAST_MAX : last_idx;
        shift_clamp = (step_shift > SHIFT_MAX) ? SHIFT_MAX : step_shift;
        nxt_idx     = (idx >= last_clamp) ? '0 : idx + ADDR_W'(1);
        v_s         = tbl[idx];
        v_e         = tbl[nxt_idx];
        k_last      = MAX_SHIFT'((32'd1 << shift_q) - 32'd1);
        // Arithmetic shift of the signed product floors toward -inf, which keeps
        // the sum inside the DAC range, so the modular add below is exact.
        prod_x      = PW'(dx_q) * PW'($signed({1'b0, k_q}));
        prod_y      = PW'(dy_q) * PW'($signed({1'b0, k_q}));
        x_smp       = s_q.x + DAC_W'(prod_x >>> shift_q);
        y_smp       = s_q.y + DAC_W'(prod_y >>> shift_q);
`ifdef XY_TRANSFORM_EN
        x_out = xform[0] ? ~x_smp : x_smp;
        y_out = y_smp;
        if (xform[1]) begin
            x_out = y_smp;
            y_out = xform[0] ? ~x_smp : x_smp;
        end
`else
        x_out = x_smp;
        y_out = y_smp;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            last_q      <= '0;
            shift_q     <= '0;
            k_q         <= '0;
            s_q         <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            xdac        <= '0;
            ydac        <= '0;
            blank       <= 1'b1;
            frame_pulse <= 1'b0;
            busy        <= 1'b0;
        end else if (ena) begin
            frame_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    blank <= 1'b1;
                    busy  <= 1'b0;
                    if (run) begin
                        state <= FETCH;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!run) begin
                        state <= IDLE;
                        blank <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        s_q     <= v_s;
                        dx_q    <= $signed({1'b0, v_e.x}) - $signed({1'b0, v_s.x});
                        dy_q    <= $signed({1'b0, v_e.y}) - $signed({1'b0, v_s.y});
                        k_q     <= '0;
                        last_q  <= last_clamp;
                        shift_q <= shift_clamp;
                        state   <= STEP;
                    end
                end
                STEP: begin
                    if (!run) begin
                        state <= IDLE;
                        blank <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        xdac        <= x_out;
                        ydac        <= y_out;
                        blank       <= s_q.blank;
                        frame_pulse <= (k_q == '0) && (idx == '0);
                        if (k_q == k_last) begin
                            idx   <= (idx >= last_q) ? '0 : idx + ADDR_W'(1);
                            state <= FETCH;
                        end else begin
                            k_q <= k_q + MAX_SHIFT'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    blank <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end else begin
            frame_pulse <= 1'b0;
        end
    end
endmodule

// File: tb/tb_xy_vector_gen.sv
// Bench for xy_vector_gen: cycle vector table, async-reset case, and model-checked traces with random ena gaps.
module tb_xy_vector_gen;
    localparam int DAC_W     = 8;
    localparam int NPTS      = 16;
    localparam int ADDR_W    = 4;
    localparam int MAX_SHIFT = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic              run;
    logic [ADDR_W-1:0] last_idx;
    logic [2:0]        step_shift;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DAC_W-1:0]  wr_x;
    logic [DAC_W-1:0]  wr_y;
    logic              wr_blank;
`ifdef XY_TRANSFORM_EN
    logic [1:0]        xform;
`endif
    logic [DAC_W-1:0]  xdac;
    logic [DAC_W-1:0]  ydac;
    logic              blank;
    logic              frame_pulse;
    logic              busy;

    xy_vector_gen #(
        .DAC_W(DAC_W), .NPTS(NPTS), .ADDR_W(ADDR_W), .MAX_SHIFT(MAX_SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .run(run),
        .last_idx(last_idx), .step_shift(step_shift),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y), .wr_blank(wr_blank),
`ifdef XY_TRANSFORM_EN
        .xform(xform),
`endif
        .xdac(xdac), .ydac(ydac), .blank(blank), .frame_pulse(frame_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       run;
        logic       ena;
        logic [7:0] x;
        logic [7:0] y;
        logic       blank;
        logic       fp;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   mdl_x[NPTS];
    int   mdl_y[NPTS];
    int   mdl_b[NPTS];
    int   held_x;
    int   held_y;
    int   q_x[$];
    int   q_y[$];
    int   q_b[$];
    int   q_f[$];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] obs();
        return {13'd0, xdac, ydac, blank, frame_pulse, busy};
    endfunction

    function automatic logic [31:0] pack(input int x, input int y, input int b, input int f, input int bz);
        return {13'd0, 8'(x), 8'(y), 1'(b), 1'(f), 1'(bz)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got x=%0d y=%0d blank=%0d fp=%0d busy=%0d, want x=%0d y=%0d blank=%0d fp=%0d busy=%0d",
                     name, got[18:11], got[10:3], got[2], got[1], got[0],
                     exp[18:11], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        int q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic add_vec(input logic r, input logic e, input int x, input int y,
                           input logic b, input logic f, input logic bz);
        vec_t v;
        v.run = r; v.ena = e; v.x = 8'(x); v.y = 8'(y); v.blank = b; v.fp = f; v.busy = bz;
        vecs.push_back(v);
    endtask

    task automatic wr(input int a, input int x, input int y, input int b, input logic en);
        ena      = en;
        wr_en    = 1'b1;
        wr_addr  = 4'(a);
        wr_x     = 8'(x);
        wr_y     = 8'(y);
        wr_blank = 1'(b);
        tick();
        wr_en    = 1'b0;
        mdl_x[a] = x;
        mdl_y[a] = y;
        mdl_b[a] = b;
    endtask

    // Expected stream of one frame: every interpolated sample, then the FETCH hold cycle.
    task automatic run_trace(input int last, input int sh, input int ncyc, input int gap_pct, input string name);
        int   se, n, p, j;
        int   ex, ey, eb, ef, ebz;
        logic en;
        se = (sh > MAX_SHIFT) ? MAX_SHIFT : sh;
        n  = 1 << se;
        q_x.delete(); q_y.delete(); q_b.delete(); q_f.delete();
        for (int i = 0; i <= last; i++) begin
            int e = (i == last) ? 0 : i + 1;
            for (int k = 0; k < n; k++) begin
                q_x.push_back(mdl_x[i] + fdiv((mdl_x[e] - mdl_x[i]) * k, n));
                q_y.push_back(mdl_y[i] + fdiv((mdl_y[e] - mdl_y[i]) * k, n));
                q_b.push_back(mdl_b[i]);
                q_f.push_back((i == 0 && k == 0) ? 1 : 0);
            end
            q_x.push_back(q_x[$]); q_y.push_back(q_y[$]); q_b.push_back(q_b[$]); q_f.push_back(0);
        end
        last_idx   = 4'(last);
        step_shift = 3'(sh);
        run        = 1'b1;
        p  = 0;
        ex = held_x; ey = held_y;
        for (int c = 0; c < ncyc; c++) begin
            en  = ($urandom_range(99) < gap_pct) ? 1'b0 : 1'b1;
            ena = en;
            tick();
            if (en) p++;
            if (p < 3) begin
                ex = held_x; ey = held_y; eb = 1; ef = 0; ebz = (p > 0) ? 1 : 0;
            end else begin
                j   = (p - 3) % q_x.size();
                ex  = q_x[j]; ey = q_y[j]; eb = q_b[j];
                ef  = en ? q_f[j] : 0;
                ebz = 1;
            end
            check(name, obs(), pack(ex, ey, eb, ef, ebz));
        end
        run = 1'b0;
        ena = 1'b1;
        tick();
        check({name, "/stop"}, obs(), pack(ex, ey, 1, 0, 0));
        held_x = ex;
        held_y = ey;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; run = 1'b0; last_idx = '0; step_shift = '0;
        wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0; wr_blank = 1'b0;
`ifdef XY_TRANSFORM_EN
        xform = 2'b00;
`endif
        for (int i = 0; i < NPTS; i++) begin
            mdl_x[i] = 0; mdl_y[i] = 0; mdl_b[i] = 0;
        end
        held_x = 0;
        held_y = 0;

        // Square-ish X ramp P0=(0,0) -> P1=(255,0), s=2, with an ena gap and a run drop.
        add_vec(1, 1,   0, 0, 1, 0, 1);
        add_vec(1, 1,   0, 0, 1, 0, 1);
        add_vec(1, 1,   0, 0, 0, 1, 1);
        add_vec(1, 1,  63, 0, 0, 0, 1);
        add_vec(1, 1, 127, 0, 0, 0, 1);
        add_vec(1, 1, 191, 0, 0, 0, 1);
        add_vec(1, 1, 191, 0, 0, 0, 1);
        add_vec(1, 1, 255, 0, 0, 0, 1);
        add_vec(1, 1, 191, 0, 0, 0, 1);
        add_vec(1, 1, 127, 0, 0, 0, 1);
        add_vec(1, 1,  63, 0, 0, 0, 1);
        add_vec(1, 1,  63, 0, 0, 0, 1);
        add_vec(1, 1,   0, 0, 0, 1, 1);
        add_vec(1, 0,   0, 0, 0, 0, 1);
        add_vec(1, 0,   0, 0, 0, 0, 1);
        add_vec(1, 0,   0, 0, 0, 0, 1);
        add_vec(1, 1,  63, 0, 0, 0, 1);
        add_vec(1, 1, 127, 0, 0, 0, 1);
        add_vec(0, 1, 127, 0, 1, 0, 0);
        add_vec(1, 0, 127, 0, 1, 0, 0);
        add_vec(1, 1, 127, 0, 1, 0, 1);
        add_vec(1, 1, 127, 0, 1, 0, 1);
        add_vec(1, 1,   0, 0, 0, 1, 1);
        add_vec(0, 1,   0, 0, 1, 0, 0);

        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("reset", obs(), pack(0, 0, 1, 0, 0));

        wr(0, 0, 0, 0, 1'b0);
        wr(1, 255, 0, 0, 1'b0);
        last_idx   = 4'd1;
        step_shift = 3'd2;
        foreach (vecs[v]) begin
            run = vecs[v].run;
            ena = vecs[v].ena;
            tick();
            check($sformatf("vec%0d", v), obs(),
                  pack(vecs[v].x, vecs[v].y, vecs[v].blank, vecs[v].fp, vecs[v].busy));
        end
        held_x = 0;
        held_y = 0;

        // Async reset in the middle of a trace, then the cleared table must trace as all zeros.
        wr(0, 200, 100, 0, 1'b1);
        wr(1, 20, 40, 1, 1'b0);
        wr(2, 90, 220, 0, 1'b1);
        wr(3, 150, 10, 1, 1'b0);
        last_idx   = 4'd3;
        step_shift = 3'd1;
        run        = 1'b1;
        ena        = 1'b1;
        repeat (5) tick();
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset", obs(), pack(0, 0, 1, 0, 0));
        tick();
        run   = 1'b0;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < NPTS; i++) begin
            mdl_x[i] = 0; mdl_y[i] = 0; mdl_b[i] = 0;
        end
        held_x = 0;
        held_y = 0;
        run_trace(3, 1, 20, 0, "zero_table");

        wr(0, 255, 255, 1, 1'b1);
        wr(1, 0, 0, 0, 1'b0);
        run_trace(1, 2, 24, 0, "blank_seg");

        wr(0, 100, 50, 0, 1'b1);
        run_trace(0, 1, 16, 0, "single_pt");

        wr(0, 0, 10, 0, 1'b0);
        wr(1, 255, 200, 1, 1'b1);
        run_trace(1, 7, 150, 15, "shift_clamp");

`ifdef XY_TRANSFORM_EN
        wr(0, 10, 20, 0, 1'b1);
        last_idx   = 4'd0;
        step_shift = 3'd0;
        xform      = 2'b11;
        run        = 1'b1;
        ena        = 1'b1;
        repeat (3) tick();
        check("xform", obs(), pack(20, 245, 0, 1, 1));
        run = 1'b0;
        tick();
        xform  = 2'b00;
        held_x = 20;
        held_y = 245;
`endif

        repeat (6) begin
            for (int a = 0; a < NPTS; a++) begin
                wr(a, int'($urandom_range(255)), int'($urandom_range(255)),
                   int'($urandom_range(1)), 1'($urandom_range(1)));
            end
            run_trace(int'($urandom_range(15)), int'($urandom_range(7)),
                      120 + int'($urandom_range(150)), 10, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
